// File: rtl/pipe_stage.sv
// Elastic valid/ready pipeline stage with synchronous flush and an optional two-entry skid buffer.
// Define PIPE_STAGE_PERF_EN to add the saturating stall_cnt/bubble_cnt performance counters.
module pipe_stage #(
   parameter int DATA_W = 32,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   input  logic              flush
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
`endif
);

   localparam logic SKID_EN = (SKID != 32'sd0);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b10,
      ST_FULL  = 2'b11
   } st_e;

   logic              r_main_valid;
   logic              r_skid_valid;
   logic [DATA_W-1:0] r_main_data;
   logic [DATA_W-1:0] r_skid_data;

   logic              w_main_valid_n;
   logic              w_skid_valid_n;
   logic [DATA_W-1:0] w_main_data_n;
   logic [DATA_W-1:0] w_skid_data_n;
   logic              w_in_fire;
   logic              w_out_fire;
   st_e               w_state;

   // With the skid buffer in_ready is a pure flop output; without it, out_ready frees the slot in the same cycle.
   assign in_ready   = SKID_EN ? !r_skid_valid : (!r_main_valid || out_ready);
   assign out_valid  = r_main_valid;
   assign out_data   = r_main_data;
   assign w_in_fire  = in_valid && in_ready;
   assign w_out_fire = r_main_valid && out_ready;
   assign w_state    = st_e'({r_main_valid, r_skid_valid});

   // Next-state and next-data for the main and skid entries; flush overrides all handshake activity.
   always_comb begin
      w_main_valid_n = r_main_valid;
      w_skid_valid_n = r_skid_valid;
      w_main_data_n  = r_main_data;
      w_skid_data_n  = r_skid_data;
      if (flush) begin
         w_main_valid_n = 1'b0;
         w_skid_valid_n = 1'b0;
      end else if (SKID_EN) begin
         case (w_state)
            ST_EMPTY: begin
               if (w_in_fire) begin
                  w_main_valid_n = 1'b1;
                  w_main_data_n  = in_data;
               end else begin
                  w_main_valid_n = 1'b0;
               end
            end
            ST_ONE: begin
               if (w_in_fire && w_out_fire) begin
                  w_main_data_n = in_data;
               end else if (w_in_fire) begin
                  w_skid_valid_n = 1'b1;
                  w_skid_data_n  = in_data;
               end else if (w_out_fire) begin
                  w_main_valid_n = 1'b0;
               end else begin
                  w_main_valid_n = 1'b1;
               end
            end
            ST_FULL: begin
               if (w_out_fire) begin
                  w_main_data_n  = r_skid_data;
                  w_skid_valid_n = 1'b0;
               end else begin
                  w_skid_valid_n = 1'b1;
               end
            end
            default: begin
               w_main_valid_n = 1'b0;
               w_skid_valid_n = 1'b0;
            end
         endcase
      end else begin
         w_skid_valid_n = 1'b0;
         if (w_in_fire) begin
            w_main_valid_n = 1'b1;
            w_main_data_n  = in_data;
         end else if (w_out_fire) begin
            w_main_valid_n = 1'b0;
         end else begin
            w_main_valid_n = r_main_valid;
         end
      end
   end

   // Storage registers; flush only drops the valid bits, reset clears data too.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
         r_main_data  <= '0;
         r_skid_data  <= '0;
      end else begin
         r_main_valid <= w_main_valid_n;
         r_skid_valid <= w_skid_valid_n;
         r_main_data  <= w_main_data_n;
         r_skid_data  <= w_skid_data_n;
      end
   end

`ifdef PIPE_STAGE_PERF_EN
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_bubble_cnt;

   assign stall_cnt  = r_stall_cnt;
   assign bubble_cnt = r_bubble_cnt;

   // Saturating stall/bubble counters; only reset clears them.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall_cnt  <= '0;
         r_bubble_cnt <= '0;
      end else begin
         if (r_main_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1'b1);
         end else begin
            r_stall_cnt <= r_stall_cnt;
         end
         if (!r_main_valid && (r_bubble_cnt != {CNT_W{1'b1}})) begin
            r_bubble_cnt <= r_bubble_cnt + CNT_W'(1'b1);
         end else begin
            r_bubble_cnt <= r_bubble_cnt;
         end
      end
   end
`endif

endmodule
